// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus_arbiter_pkg : bus request/response types shared by the arbiter
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef logic [7:0] strobe_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [63:0] addr;
    msize_t      size;
    strobe_t     strobe;
    logic [63:0] wdata;
  } dbus_req_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [63:0] addr;
    msize_t      size;
    strobe_t     strobe;
    logic [63:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        ok;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

  // Instructions are 32 bits on a 64-bit bus; address bit 2 picks the half.
  function automatic logic [31:0] fetch_word(input logic hi, input logic [63:0] data);
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus_arbiter : shares the core bus between fetch and data, data first
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic        dreq_write,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_wdata,
  output logic        dresp_ok,
  output logic [63:0] dresp_data,
  output logic        creq_valid,
  output logic        creq_write,
  output logic [63:0] creq_addr,
  output logic [2:0]  creq_size,
  output logic [7:0]  creq_strobe,
  output logic [63:0] creq_wdata,
  input  logic        cresp_ok,
  input  logic [63:0] cresp_data
);

  localparam int            CW       = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C  = CW'(STARVE_LIMIT);
  localparam logic [1:0]    ST_IDLE  = 2'(IDLE);
  localparam logic [1:0]    ST_IBUSY = 2'(IBUSY);
  localparam logic [1:0]    ST_DBUSY = 2'(DBUSY);

  ibus_req_t     ireq;
  dbus_req_t     dreq;
  cbus_resp_t    cresp;
  logic [1:0]    state_q, state_d;
  cbus_req_t     req_q, req_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starved;

  assign ireq  = '{valid: ireq_valid, addr: ireq_addr};
  assign dreq  = '{valid: dreq_valid, write: dreq_write, addr: dreq_addr,
                   size: msize_t'(dreq_size), strobe: dreq_strobe, wdata: dreq_wdata};
  assign cresp = '{ok: cresp_ok, data: cresp_data};

  assign starved = ireq.valid && (starve_cnt_q == LIMIT_C);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (dreq.valid && !starved) begin
          req_d   = '{valid: 1'b1, write: dreq.write, addr: dreq.addr,
                      size: dreq.size, strobe: dreq.strobe, wdata: dreq.wdata};
          state_d = ST_DBUSY;
          // Only data grants that actually make a fetch wait count toward starvation.
          if (!ireq.valid)
            starve_cnt_d = '0;
          else if (starve_cnt_q != LIMIT_C)
            starve_cnt_d = starve_cnt_q + CW'(1);
        end else if (ireq.valid) begin
          req_d        = '{valid: 1'b1, write: 1'b0, addr: ireq.addr,
                           size: MSIZE4, strobe: '0, wdata: '0};
          state_d      = ST_IBUSY;
          starve_cnt_d = '0;
        end
      end
      ST_IBUSY, ST_DBUSY: begin
        if (cresp.ok) begin
          req_d.valid = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        req_d.valid = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign creq_valid  = req_q.valid;
  assign creq_write  = req_q.write;
  assign creq_addr   = req_q.addr;
  assign creq_size   = req_q.size;
  assign creq_strobe = req_q.strobe;
  assign creq_wdata  = req_q.wdata;

  assign iresp_ok   = (state_q == ST_IBUSY) && cresp.ok;
  assign dresp_ok   = (state_q == ST_DBUSY) && cresp.ok;
  assign iresp_data = iresp_ok ? fetch_word(req_q.addr[2], cresp.data) : '0;
  assign dresp_data = dresp_ok ? cresp.data : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter : scoreboard bench for mem_bus_arbiter
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic        dreq_write;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_wdata;
  logic        dresp_ok;
  logic [63:0] dresp_data;
  logic        creq_valid;
  logic        creq_write;
  logic [63:0] creq_addr;
  logic [2:0]  creq_size;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_wdata;
  logic        cresp_ok;
  logic [63:0] cresp_data;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_ok(iresp_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
    .dresp_ok(dresp_ok), .dresp_data(dresp_data),
    .creq_valid(creq_valid), .creq_write(creq_write), .creq_addr(creq_addr),
    .creq_size(creq_size), .creq_strobe(creq_strobe), .creq_wdata(creq_wdata),
    .cresp_ok(cresp_ok), .cresp_data(cresp_data)
  );

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
  } req_t;

  typedef struct {
    logic        is_d;
    logic [63:0] data;
  } resp_t;

  req_t        exp_req_q[$];
  resp_t       exp_resp_q[$];
  logic [63:0] bus_data_q[$];
  int          errors = 0;
  int          checks = 0;
  int          bus_stall = 0;
  logic        spurious = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic w, input logic [63:0] a, input logic [2:0] s,
                          input logic [7:0] st, input logic [63:0] wd);
    req_t r;
    r.write = w; r.addr = a; r.size = s; r.strobe = st; r.wdata = wd;
    exp_req_q.push_back(r);
  endtask

  // Queue what the bus will return and what the requester must see for it.
  task automatic push_resp(input logic is_d, input logic [63:0] bus, input logic [63:0] exp);
    resp_t r;
    r.is_d = is_d; r.data = exp;
    exp_resp_q.push_back(r);
    bus_data_q.push_back(bus);
  endtask

  task automatic wait_ok(input logic is_d);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (is_d ? dresp_ok : iresp_ok) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ok expected ok within 300 cycles", is_d ? "dresp" : "iresp");
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the ok.
  task automatic do_dreq(input logic w, input logic [63:0] a, input logic [2:0] s,
                         input logic [7:0] st, input logic [63:0] wd, input logic keep);
    dreq_valid = 1'b1; dreq_write = w; dreq_addr = a;
    dreq_size = s; dreq_strobe = st; dreq_wdata = wd;
    wait_ok(1'b1);
    @(posedge clk);
    #1;
    if (!keep) begin
      dreq_valid = 1'b0; dreq_write = 1'b0; dreq_addr = '0;
      dreq_size = '0; dreq_strobe = '0; dreq_wdata = '0;
    end
  endtask

  task automatic do_ireq(input logic [63:0] a);
    ireq_valid = 1'b1; ireq_addr = a;
    wait_ok(1'b0);
    @(posedge clk);
    #1;
    ireq_valid = 1'b0; ireq_addr = '0;
  endtask

  // Bus responder: answers bus_stall cycles after a request appears.
  initial begin : bus_model
    logic busy;
    int   wcnt;
    busy = 1'b0; wcnt = 0;
    cresp_ok = 1'b0; cresp_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (cresp_ok) begin
        cresp_ok = 1'b0; cresp_data = '0;
      end else if (!resetn) begin
        busy = 1'b0;
      end else if (spurious && !busy && !creq_valid) begin
        cresp_ok = 1'b1; cresp_data = 64'hFFFF_0000_FFFF_0000; spurious = 1'b0;
      end else begin
        if (creq_valid && !busy) begin
          busy = 1'b1; wcnt = bus_stall;
        end
        if (busy) begin
          if (wcnt == 0) begin
            cresp_ok = 1'b1;
            cresp_data = (bus_data_q.size() > 0) ? bus_data_q.pop_front() : 64'h0;
            busy = 1'b0;
          end else begin
            wcnt--;
          end
        end
      end
    end
  end

  initial begin : monitor
    logic  prev_v;
    req_t  cur;
    resp_t r;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!iresp_ok) chk("iresp_data_zero", {32'h0, iresp_data}, 64'h0);
      if (!dresp_ok) chk("dresp_data_zero", dresp_data, 64'h0);
      if (creq_valid && !prev_v) begin
        checks++;
        if (exp_req_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: got request addr 0x%0h expected none", creq_addr);
        end else begin
          cur = exp_req_q.pop_front();
          chk("creq_write",  {63'h0, creq_write}, {63'h0, cur.write});
          chk("creq_addr",   creq_addr, cur.addr);
          chk("creq_size",   {61'h0, creq_size}, {61'h0, cur.size});
          chk("creq_strobe", {56'h0, creq_strobe}, {56'h0, cur.strobe});
          chk("creq_wdata",  creq_wdata, cur.wdata);
        end
      end else if (creq_valid) begin
        chk("creq_addr_stable",  creq_addr, cur.addr);
        chk("creq_wdata_stable", creq_wdata, cur.wdata);
      end
      if (iresp_ok && dresp_ok) begin
        checks++;
        errors++;
        $display("FAIL both_ok: got iresp_ok=1 dresp_ok=1 expected at most one");
      end else if (iresp_ok || dresp_ok) begin
        if (exp_resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ok: got iresp_ok=%0b dresp_ok=%0b expected none", iresp_ok, dresp_ok);
        end else begin
          r = exp_resp_q.pop_front();
          chk("resp_side", {63'h0, dresp_ok}, {63'h0, r.is_d});
          chk("resp_data", dresp_ok ? dresp_data : {32'h0, iresp_data}, r.data);
        end
      end
      prev_v = creq_valid;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    resetn = 1'b0;
    ireq_valid = 1'b0; ireq_addr = '0;
    dreq_valid = 1'b0; dreq_write = 1'b0; dreq_addr = '0;
    dreq_size = '0; dreq_strobe = '0; dreq_wdata = '0;
    tick(3);

    // Reset state
    @(negedge clk);
    chk("rst_creq_valid", {63'h0, creq_valid}, 64'h0);
    chk("rst_iresp_ok",   {63'h0, iresp_ok}, 64'h0);
    chk("rst_dresp_ok",   {63'h0, dresp_ok}, 64'h0);
    chk("rst_state",      {62'h0, dut.state_q}, 64'h0);
    chk("rst_starve_cnt", {61'h0, dut.starve_cnt_q}, 64'h0);
    chk("rst_creq_addr",  creq_addr, 64'h0);
    chk("rst_creq_wdata", creq_wdata, 64'h0);
    tick(1);
    resetn = 1'b1;
    tick(1);

    // Single fetch from the upper word
    bus_stall = 1;
    push_req(1'b0, 64'h8000_0004, 3'd2, 8'h00, 64'h0);
    push_resp(1'b0, 64'h1111_2222_3333_4444, 64'h1111_2222);
    do_ireq(64'h8000_0004);
    chk("idle_after_fetch", {62'h0, dut.state_q}, 64'h0);

    // Simultaneous store and fetch: data first
    bus_stall = 0;
    push_req(1'b1, 64'h100, 3'd2, 8'hFF, 64'hDEAD_BEEF);
    push_resp(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 64'hAAAA_BBBB_CCCC_DDDD);
    push_req(1'b0, 64'h8000_0000, 3'd2, 8'h00, 64'h0);
    push_resp(1'b0, 64'h5555_6666_7777_8888, 64'h7777_8888);
    fork
      do_dreq(1'b1, 64'h100, 3'd2, 8'hFF, 64'hDEAD_BEEF, 1'b0);
      do_ireq(64'h8000_0000);
    join
    tick(1);

    // Starvation: D,D,D,D,I,D,D
    for (int k = 0; k < 4; k++) begin
      push_req(1'b0, 64'h300 + 64'(8 * k), 3'd3, 8'h00, 64'h0);
      push_resp(1'b1, 64'h1000 + 64'(k), 64'h1000 + 64'(k));
    end
    push_req(1'b0, 64'h8000_0010, 3'd2, 8'h00, 64'h0);
    push_resp(1'b0, 64'h9999_8888_7777_6666, 64'h7777_6666);
    for (int k = 4; k < 6; k++) begin
      push_req(1'b0, 64'h300 + 64'(8 * k), 3'd3, 8'h00, 64'h0);
      push_resp(1'b1, 64'h1000 + 64'(k), 64'h1000 + 64'(k));
    end
    fork
      begin
        for (int k = 0; k < 6; k++)
          do_dreq(1'b0, 64'h300 + 64'(8 * k), 3'd3, 8'h00, 64'h0, k < 5);
      end
      do_ireq(64'h8000_0010);
      begin
        for (int i = 0; i < 300; i++) begin
          @(negedge clk);
          if (iresp_ok) begin
            chk("starve_cnt_after_fetch", {61'h0, dut.starve_cnt_q}, 64'h0);
            break;
          end
        end
      end
    join
    tick(1);

    // Bus stall of 10 cycles with a data request arriving mid-fetch
    bus_stall = 10;
    push_req(1'b0, 64'h8000_0020, 3'd2, 8'h00, 64'h0);
    push_resp(1'b0, 64'hCAFE_F00D_1234_5678, 64'h1234_5678);
    push_req(1'b0, 64'h400, 3'd3, 8'h00, 64'h0);
    push_resp(1'b1, 64'h0BAD_0BAD_0BAD_0BAD, 64'h0BAD_0BAD_0BAD_0BAD);
    fork
      do_ireq(64'h8000_0020);
      begin
        tick(3);
        do_dreq(1'b0, 64'h400, 3'd3, 8'h00, 64'h0, 1'b0);
      end
      begin
        n = 0;
        for (int i = 0; i < 300; i++) begin
          @(negedge clk);
          if (creq_valid) n++;
          if (iresp_ok) break;
        end
        chk("stall_cycles_to_ok", 64'(n), 64'd11);
      end
    join
    bus_stall = 0;
    tick(1);

    // Reset in the middle of a store
    bus_stall = 5;
    push_req(1'b1, 64'h500, 3'd3, 8'hFF, 64'h1234);
    dreq_valid = 1'b1; dreq_write = 1'b1; dreq_addr = 64'h500;
    dreq_size = 3'd3; dreq_strobe = 8'hFF; dreq_wdata = 64'h1234;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (creq_valid) break;
    end
    tick(2);
    resetn = 1'b0;
    dreq_valid = 1'b0; dreq_write = 1'b0; dreq_addr = '0;
    dreq_size = '0; dreq_strobe = '0; dreq_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_creq_valid", {63'h0, creq_valid}, 64'h0);
    chk("rst_mid_state",      {62'h0, dut.state_q}, 64'h0);
    chk("rst_mid_dresp_ok",   {63'h0, dresp_ok}, 64'h0);
    tick(1);
    resetn = 1'b1;
    bus_stall = 0;
    tick(1);
    push_req(1'b0, 64'h8000_0040, 3'd2, 8'h00, 64'h0);
    push_resp(1'b0, 64'h4444_3333_2222_1111, 64'h2222_1111);
    do_ireq(64'h8000_0040);
    tick(1);

    // Load data path, full doubleword
    push_req(1'b0, 64'h200, 3'd3, 8'h00, 64'h0);
    push_resp(1'b1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    do_dreq(1'b0, 64'h200, 3'd3, 8'h00, 64'h0, 1'b0);
    tick(1);

    // Bus completion while idle must not disturb anything
    spurious = 1'b1;
    @(negedge clk);
    chk("idle_cresp_iresp_ok", {63'h0, iresp_ok}, 64'h0);
    chk("idle_cresp_dresp_ok", {63'h0, dresp_ok}, 64'h0);
    chk("idle_cresp_creq",     {63'h0, creq_valid}, 64'h0);
    tick(2);
    chk("idle_cresp_state",    {62'h0, dut.state_q}, 64'h0);

    tick(3);
    chk("exp_req_left",  64'(exp_req_q.size()), 64'h0);
    chk("exp_resp_left", 64'(exp_resp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
